// File: rtl/hub_frame_packer_if.sv
// rtl/hub_frame_packer_if.sv - pop-style input and shift-style output bundle of the frame packer
interface hub_frame_packer_if;
    logic        in_pop;
    logic        in_nempty;
    logic [31:0] in_data;
    logic        out_shift;
    logic        out_full;
    logic [31:0] out_data;
    logic [7:0]  frame_seq;

    modport master (
        output in_pop,
        input  in_nempty,
        input  in_data,
        output out_shift,
        input  out_full,
        output out_data,
        output frame_seq
    );

    modport slave (
        input  in_pop,
        output in_nempty,
        output in_data,
        input  out_shift,
        output out_full,
        input  out_data,
        input  frame_seq
    );
endinterface

// File: rtl/hub_frame_packer.sv
// rtl/hub_frame_packer.sv - packs mux words into header-prefixed frames with idle-timeout flush
module hub_frame_packer #(
    parameter int unsigned FRAME_WORDS = 16,
    parameter int unsigned TIMEOUT     = 256,
    parameter logic [7:0]  MAGIC       = 8'hF5
) (
    input logic                clk,
    input logic                rstn,
    hub_frame_packer_if.master bus
);
    localparam int CW = $clog2(FRAME_WORDS + 1);
    localparam int AW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] FULL      = CW'(FRAME_WORDS);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_HEADER = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [7:0]    seq_q, seq_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [31:0]   buf_q [FRAME_WORDS];

    logic          pop;
    logic          shift;
    logic [31:0]   dout;
    logic [15:0]   count16;
    logic          last_word;

    assign count16   = 16'(count_q);
    assign last_word = (CW'(rd_q) == count_q - CW'(1));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idle_d  = idle_q;
        seq_d   = seq_q;
        rd_d    = rd_q;
        pop     = 1'b0;
        shift   = 1'b0;
        dout    = '0;
        // Combinational handshakes stay quiet while reset is asserted.
        if (rstn) begin
            case (state_q)
                ST_FILL: begin
                    pop = bus.in_nempty && (count_q < FULL);
                    if (pop) begin
                        count_d = count_q + CW'(1);
                        idle_d  = '0;
                        // Leaving on the filling pop keeps a full frame at 2*FRAME_WORDS+1 cycles.
                        if (count_d == FULL) begin
                            state_d = ST_HEADER;
                        end
                    end else if (count_q == FULL) begin
                        state_d = ST_HEADER;
                    end else if (count_q != '0) begin
                        if (idle_q == IDLE_LAST) begin
                            state_d = ST_HEADER;
                        end else begin
                            idle_d = idle_q + IW'(1);
                        end
                    end
                end
                ST_HEADER: begin
                    dout  = {MAGIC, seq_q, count16};
                    shift = !bus.out_full;
                    if (shift) begin
                        rd_d    = '0;
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    dout  = buf_q[rd_q];
                    shift = !bus.out_full;
                    if (shift) begin
                        rd_d = rd_q + AW'(1);
                        if (last_word) begin
                            seq_d   = seq_q + 8'd1;
                            count_d = '0;
                            idle_d  = '0;
                            rd_d    = '0;
                            state_d = ST_FILL;
                        end
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_FILL;
            count_q <= '0;
            idle_q  <= '0;
            seq_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idle_q  <= idle_d;
            seq_q   <= seq_d;
            rd_q    <= rd_d;
        end
    end

    // Payload storage carries no reset; only popped words are ever written.
    always_ff @(posedge clk) begin
        if (pop) begin
            buf_q[count_q[AW-1:0]] <= bus.in_data;
        end
    end

    assign bus.in_pop    = pop;
    assign bus.out_shift = shift;
    assign bus.out_data  = dout;
    assign bus.frame_seq = seq_q;
endmodule

// File: tb/tb_hub_frame_packer.sv
// tb/tb_hub_frame_packer.sv - directed self-checking bench for hub_frame_packer
module tb_hub_frame_packer;
    localparam int TIMEOUT_C = 256;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    hub_frame_packer_if bus ();

    hub_frame_packer dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_pop_cyc = 0;
    logic [31:0] src_q[$];
    logic [31:0] got_q[$];
    int          sc_q[$];
    logic [31:0] exp_q[$];
    logic        rand_full = 1'b0;
    logic        chk_stable = 1'b0;
    logic        prev_full = 1'b0;
    logic        prev_act = 1'b0;
    logic [31:0] prev_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.in_nempty = (src_q.size() > 0);
        bus.in_data   = (src_q.size() > 0) ? src_q[0] : 32'hxxxx_xxxx;
        bus.out_full  = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic step();
        logic        popped;
        logic [31:0] tmp;
        @(negedge clk);
        cyc++;
        if (bus.out_shift) begin
            got_q.push_back(bus.out_data);
            sc_q.push_back(cyc);
        end
        if (chk_stable && prev_full && prev_act) check("stable_while_full", bus.out_data, prev_data);
        prev_full = bus.out_full;
        prev_act  = (bus.out_data != 32'h0);
        prev_data = bus.out_data;
        popped = bus.in_pop;
        if (popped) last_pop_cyc = cyc;
        @(posedge clk);
        #1;
        if (popped) tmp = src_q.pop_front();
        drive();
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(got_q.size()), 32'(n));
    endtask

    task automatic clear_out();
        got_q.delete();
        sc_q.delete();
    endtask

    task automatic pulse_reset();
        #2 rstn = 1'b0;
        src_q.delete();
        drive();
        @(posedge clk);
        @(posedge clk);
        #3 rstn = 1'b1;
        clear_out();
    endtask

    initial begin
        rstn          = 1'b0;
        bus.in_nempty = 1'b1;
        bus.in_data   = 32'h1234_5678;
        bus.out_full  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_in_pop", 32'(bus.in_pop), 32'h0);
        check("rst_out_shift", 32'(bus.out_shift), 32'h0);
        check("rst_out_data", bus.out_data, 32'h0);
        check("rst_frame_seq", 32'(bus.frame_seq), 32'h0);
        src_q.delete();
        drive();
        @(posedge clk);
        #3 rstn = 1'b1;

        // Full frame, back-to-back input
        for (int i = 1; i <= 16; i++) src_q.push_back(32'(i));
        drive();
        run_until(17, 100, "f1_count");
        if (got_q.size() == 17) begin
            check("f1_header", got_q[0], 32'hF500_0010);
            for (int i = 1; i <= 16; i++) check("f1_payload", got_q[i], 32'(i));
            check("f1_consecutive", 32'(sc_q[16] - sc_q[0]), 32'd16);
        end
        check("f1_frame_seq", 32'(bus.frame_seq), 32'h1);

        // Partial frame flushed by idle timeout
        clear_out();
        src_q.push_back(32'hA1);
        src_q.push_back(32'hA2);
        src_q.push_back(32'hA3);
        drive();
        run_until(4, 400, "to_count");
        if (got_q.size() == 4) begin
            check("to_header", got_q[0], 32'hF501_0003);
            check("to_w0", got_q[1], 32'hA1);
            check("to_w2", got_q[3], 32'hA3);
            check("to_latency", 32'(sc_q[0] - last_pop_cyc), 32'(TIMEOUT_C + 1));
        end

        // Word arriving on the last idle cycle joins the frame and restarts the timeout
        begin
            int b1, b2;
            clear_out();
            src_q.push_back(32'hB1);
            drive();
            while (src_q.size() > 0 && cyc < 100000) step();
            b1 = last_pop_cyc;
            while (cyc < b1 + TIMEOUT_C - 1) step();
            src_q.push_back(32'hB2);
            drive();
            run_until(3, 600, "race_count");
            b2 = last_pop_cyc;
            check("race_pop_cycle", 32'(b2 - b1), 32'(TIMEOUT_C));
            if (got_q.size() == 3) begin
                check("race_header", got_q[0], 32'hF502_0002);
                check("race_w1", got_q[2], 32'hB2);
                check("race_latency", 32'(sc_q[0] - b2), 32'(TIMEOUT_C + 1));
            end
        end

        // Two full frames with random backpressure
        clear_out();
        exp_q.delete();
        rand_full  = 1'b1;
        chk_stable = 1'b1;
        exp_q.push_back(32'hF503_0010);
        for (int i = 0; i < 16; i++) exp_q.push_back(32'hC000_0000 + 32'(i) + 32'h100);
        exp_q.push_back(32'hF504_0010);
        for (int i = 16; i < 32; i++) exp_q.push_back(32'hC000_0000 + 32'(i) + 32'h100);
        for (int i = 0; i < 32; i++) src_q.push_back(32'hC000_0000 + 32'(i) + 32'h100);
        drive();
        run_until(34, 2000, "bp_count");
        if (got_q.size() == 34) begin
            for (int i = 0; i < 34; i++) check("bp_stream", got_q[i], exp_q[i]);
        end
        rand_full  = 1'b0;
        chk_stable = 1'b0;
        prev_full  = 1'b0;
        repeat (5) step();
        check("bp_no_dup", 32'(got_q.size()), 32'd34);

        // Asynchronous reset in the middle of draining frame seq 5
        clear_out();
        for (int i = 0; i < 16; i++) src_q.push_back(32'hD000_0000 + 32'(i) + 32'h1);
        drive();
        run_until(4, 100, "mid_count");
        if (got_q.size() == 4) check("mid_header", got_q[0], 32'hF505_0010);
        #2 rstn = 1'b0;
        #1;
        check("async_out_shift", 32'(bus.out_shift), 32'h0);
        check("async_out_data", bus.out_data, 32'h0);
        check("async_frame_seq", 32'(bus.frame_seq), 32'h0);
        check("async_in_pop", 32'(bus.in_pop), 32'h0);
        src_q.delete();
        drive();
        @(posedge clk);
        @(posedge clk);
        #3 rstn = 1'b1;
        clear_out();
        src_q.push_back(32'hE1);
        src_q.push_back(32'hE2);
        src_q.push_back(32'hE3);
        drive();
        run_until(4, 400, "post_rst_count");
        if (got_q.size() == 4) begin
            check("post_rst_header", got_q[0], 32'hF500_0003);
            check("post_rst_w0", got_q[1], 32'hE1);
            check("post_rst_w2", got_q[3], 32'hE3);
        end
        repeat (20) step();
        check("post_rst_no_stale", 32'(got_q.size()), 32'd4);

        // 257 frames: sequence wraps through 0xFF back to 0x00
        pulse_reset();
        for (int f = 0; f < 257; f++) begin
            clear_out();
            for (int i = 0; i < 16; i++) src_q.push_back(32'(f * 16 + i + 1));
            drive();
            run_until(17, 60, "wrap_count");
            if (got_q.size() == 17) begin
                check("wrap_header", got_q[0], {8'hF5, 8'(f), 16'h0010});
                check("wrap_last", got_q[16], 32'(f * 16 + 16));
            end
        end
        check("wrap_frame_seq", 32'(bus.frame_seq), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
